des_io_loader: RTL and testbench
================================

DES_IO_LOADER -- requirements
Module: des_io_loader

Interface
REQ-001 Parameter LATENCY, default 17, is the number of cycles from the flag_s pulse to a valid des_out from the DES core.
REQ-002 Parameter MODE, default 1, is the constant driven on flag (1 = encrypt, 0 = decrypt).
REQ-003 Ports:
- clk        input   1   single clock, rising-edge.
- rst        input   1   asynchronous, active-low reset.
- byte_in    input   8   load byte, MSB first.
- byte_sel   input   1   0 = data byte, 1 = key byte.
- byte_valid input   1   byte_in is valid.
- byte_ready output  1   byte accepted when byte_valid and byte_ready are both high.
- des_in     output  [0:63]  data word to the DES core.
- key_in     output  [0:63]  key word to the DES core.
- flag       output  1   mode to the DES core, equal to MODE.
- flag_s     output  1   one-cycle start pulse to the DES core.
- des_out    input   [0:63]  result from the DES core.
- res_out    output  [0:63]  captured result.
- res_valid  output  1   res_out is valid.
- res_ready  input   1   consumer accepts res_out.
- busy       output  1   high in every state except IDLE.
- key_err    output  1   sticky key-parity error.

Function
REQ-004 The FSM SHALL have states IDLE, LOAD, START, WAIT and OUT.
REQ-005 An accepted data byte SHALL shift into des_in from the bit-63 end (des_in <= {des_in[8:63], byte_in}); the first byte SHALL end in bits 0..7 after 8 bytes.
REQ-006 Key bytes SHALL load into key_in by the same rule.
REQ-007 Loading SHALL use 4-bit counters dcnt and kcnt, each saturating at 8.
REQ-008 byte_ready SHALL be high only in IDLE or LOAD, and only when the counter selected by byte_sel is below 8.
- A byte offered to a full buffer is not accepted and does not change that buffer.
REQ-009 IDLE SHALL go to LOAD on the first accepted byte.
REQ-010 LOAD SHALL go to START in the cycle after dcnt == 8 and kcnt == 8.
- Data and key bytes may interleave in any order.
REQ-011 In START, flag_s SHALL be high for exactly one cycle, then the FSM SHALL go to WAIT.
- des_in and key_in SHALL stay stable from START until the block returns to IDLE.
REQ-012 WAIT SHALL count LATENCY cycles, starting at the cycle after flag_s.
- In the last WAIT cycle, the block SHALL register des_out into res_out and go to OUT with res_valid = 1.
- Total latency is LATENCY+1 cycles from the flag_s cycle to the first cycle of res_valid.
REQ-013 In OUT, res_valid SHALL stay high and res_out SHALL stay stable until res_ready is high.
- On the handshake cycle, the block SHALL clear res_valid, dcnt and kcnt and go to IDLE.
- No bytes SHALL be accepted in that cycle.
REQ-014 res_ready while res_valid is low SHALL have no effect.
REQ-015 byte_valid outside IDLE/LOAD SHALL have no effect.
REQ-016 If LATENCY == 0, the block SHALL capture des_out in the cycle after START.

Reset
REQ-017 While rst is low, all state SHALL clear immediately and asynchronously:
- FSM = IDLE; dcnt = kcnt = 0;
- des_in, key_in, res_out = 0;
- flag_s, res_valid, busy, key_err, byte_ready = 0;
- flag = MODE.
REQ-018 A reset asserted in any state, including mid-load, WAIT or OUT, SHALL discard all partial or pending data.
- byte_ready SHALL return to 1 in the first clk edge after rst is released.

Configuration
REQ-019 With macro DES_LOADER_PARITY_EN defined, each accepted key byte SHALL be checked for odd parity.
- On a failure, key_err SHALL set and stay set until reset.
- LOAD SHALL then return to IDLE without a START, clearing both counters.
REQ-020 Without DES_LOADER_PARITY_EN, no parity check SHALL exist, key_err SHALL be constant 0, and LOAD behaviour SHALL be as REQ-010.

Verification
REQ-021 Reset, then load data 01 23 45 67 89 AB CD EF and key 13 34 57 79 9B BC DF F1, with des_out driven to 85E813540F0AB405 → expected response:
- des_in = 0123456789ABCDEF and key_in = 133457799BBCDFF1;
- one flag_s pulse;
- res_valid 18 cycles after flag_s, with res_out = 85E813540F0AB405.
REQ-022 Interleave key and data bytes alternately, then offer a 9th data byte → it is held off (byte_ready = 0) and des_in is unchanged.
REQ-023 Hold res_ready low for 5 cycles in OUT while des_out changes → res_out stays 85E813540F0AB405; on res_ready the block returns to IDLE and busy = 0.
REQ-024 Pulse rst low during WAIT → no res_valid follows, all outputs are 0, and a following full load completes normally.
REQ-025 With DES_LOADER_PARITY_EN, key byte 0x12 (even parity) → key_err = 1, no flag_s pulse, counters cleared; without the macro, the same stimulus → normal completion.

Source files
------------

// File: rtl/des_io_loader.sv
// rtl/des_io_loader.sv - byte-serial data/key loader and result capture around a fixed-latency DES core
// Optional key-byte odd-parity check: define DES_LOADER_PARITY_EN.
module des_io_loader #(
    parameter int LATENCY = 17,
    parameter int MODE    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_in,
    input  logic        byte_sel,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [0:63] des_in,
    output logic [0:63] key_in,
    output logic        flag,
    output logic        flag_s,
    input  logic [0:63] des_out,
    output logic [0:63] res_out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        busy,
    output logic        key_err
);

    localparam int CW = (LATENCY < 2) ? 1 : $clog2(LATENCY);
    localparam logic [CW-1:0] WLAST = CW'((LATENCY > 1) ? LATENCY - 1 : 0);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        OUT   = 3'd4
    } state_t;

    state_t        state, state_n;
    logic [3:0]    dcnt, kcnt;
    logic [CW-1:0] wcnt;
    logic          rdy_en;
    logic          sel_full;
    logic          accept;
    logic          d_acc;
    logic          k_acc;
    logic          wait_last;
    logic          par_fail;

    assign flag = (MODE != 0);

    always_comb begin
        sel_full   = byte_sel ? kcnt[3] : dcnt[3];
        // rdy_en keeps byte_ready low while reset is held and until the first edge after release
        byte_ready = rdy_en && ((state == IDLE) || (state == LOAD)) && !sel_full;
        accept     = byte_valid && byte_ready;
        d_acc      = accept && !byte_sel;
        k_acc      = accept && byte_sel;
        wait_last  = (LATENCY <= 1) || (wcnt == WLAST);
        flag_s     = (state == START);
        res_valid  = (state == OUT);
        busy       = (state != IDLE);
`ifdef DES_LOADER_PARITY_EN
        par_fail   = k_acc && !(^byte_in);
`else
        par_fail   = 1'b0;
`endif
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept && !par_fail) state_n = LOAD;
            LOAD: begin
                if (par_fail)
                    state_n = IDLE;
                else if (dcnt[3] && kcnt[3])
                    state_n = START;
            end
            START:   state_n = WAIT;
            WAIT:    if (wait_last) state_n = OUT;
            OUT:     if (res_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy_en  <= 1'b0;
            dcnt    <= 4'd0;
            kcnt    <= 4'd0;
            wcnt    <= '0;
            des_in  <= '0;
            key_in  <= '0;
            res_out <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (d_acc) begin
                des_in <= {des_in[8:63], byte_in};
                dcnt   <= dcnt + 4'd1;
            end
            if (k_acc) begin
                key_in <= {key_in[8:63], byte_in};
                kcnt   <= kcnt + 4'd1;
            end
            // a bad key byte abandons the whole load, data included
            if (par_fail) begin
                dcnt <= 4'd0;
                kcnt <= 4'd0;
            end
            if (state == START)
                wcnt <= '0;
            if (state == WAIT) begin
                wcnt <= wcnt + CW'(1);
                if (wait_last)
                    res_out <= des_out;
            end
            if ((state == OUT) && res_ready) begin
                dcnt <= 4'd0;
                kcnt <= 4'd0;
            end
        end
    end

`ifdef DES_LOADER_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            key_err <= 1'b0;
        else if (par_fail)
            key_err <= 1'b1;
    end
`else
    assign key_err = 1'b0;
`endif

endmodule

// File: tb/tb_des_io_loader.sv
// tb/tb_des_io_loader.sv - directed self-checking bench for des_io_loader
module tb_des_io_loader;

    localparam logic [63:0] D1  = 64'h0123456789ABCDEF;
    localparam logic [63:0] D2  = 64'hFEDCBA9876543210;
    localparam logic [63:0] K1  = 64'h133457799BBCDFF1;
    localparam logic [63:0] RES = 64'h85E813540F0AB405;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_sel = 1'b0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic [0:63] des_in;
    logic [0:63] key_in;
    logic        flag;
    logic        flag_s;
    logic [0:63] des_out = RES;
    logic [0:63] res_out;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic        busy;
    logic        key_err;

    int total = 0;
    int bad = 0;
    int fs_cnt = 0;
    int rv_cnt = 0;

    des_io_loader dut (
        .clk(clk), .rst(rst), .byte_in(byte_in), .byte_sel(byte_sel),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .des_in(des_in),
        .key_in(key_in), .flag(flag), .flag_s(flag_s), .des_out(des_out),
        .res_out(res_out), .res_valid(res_valid), .res_ready(res_ready),
        .busy(busy), .key_err(key_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (flag_s) fs_cnt++;
        if (res_valid) rv_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send(input logic sel, input logic [7:0] b);
        int n = 0;
        byte_sel = sel;
        byte_in = b;
        byte_valid = 1'b1;
        #1;
        while (!byte_ready && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!byte_ready) check("send_timeout", 64'd0, 64'd1);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic load(input logic [63:0] d, input logic [63:0] k, input bit inter);
        if (inter) begin
            for (int i = 0; i < 8; i++) begin
                send(1'b0, d[63-8*i -: 8]);
                send(1'b1, k[63-8*i -: 8]);
            end
        end else begin
            for (int i = 0; i < 8; i++) send(1'b0, d[63-8*i -: 8]);
            for (int i = 0; i < 8; i++) send(1'b1, k[63-8*i -: 8]);
        end
    endtask

    task automatic wait_flag(input string tag);
        int n = 0;
        while (!flag_s && n < 60) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(flag_s), 64'd1);
    endtask

    task automatic wait_valid(input string tag, output int lat);
        lat = 0;
        while (!res_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check(tag, 64'(res_valid), 64'd1);
    endtask

    task automatic handshake(input string tag);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_rv"}, 64'(res_valid), 64'd0);
    endtask

    initial begin
        int lat;
        int fs0;
        int rv0;

        // reset state
        #1;
        check("rst_ready", 64'(byte_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_flag_s", 64'(flag_s), 64'd0);
        check("rst_rv", 64'(res_valid), 64'd0);
        check("rst_key_err", 64'(key_err), 64'd0);
        check("rst_flag", 64'(flag), 64'd1);
        check("rst_bufs", 64'(des_in | key_in | res_out), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 64'(byte_ready), 64'd1);

        // sequential load, known-answer latency and capture
        fs0 = fs_cnt;
        load(D1, K1, 1'b0);
        check("kat_des_in", des_in, D1);
        check("kat_key_in", key_in, K1);
        wait_flag("kat_flag_s");
        wait_valid("kat_valid", lat);
        check("kat_latency", 64'(lat), 64'd18);
        check("kat_fs_pulses", 64'(fs_cnt - fs0), 64'd1);
        check("kat_res_out", res_out, RES);
        check("kat_stable_din", des_in, D1);
        handshake("kat_hs");

        // res_ready with nothing pending
        res_ready = 1'b1;
        repeat (2) @(negedge clk);
        res_ready = 1'b0;
        check("idle_rr_busy", 64'(busy), 64'd0);
        check("idle_rr_rv", 64'(res_valid), 64'd0);

        // interleaved load with a ninth data byte offered against a full buffer
        for (int i = 0; i < 8; i++) begin
            send(1'b0, D2[63-8*i -: 8]);
            if (i < 7) send(1'b1, K1[63-8*i -: 8]);
        end
        byte_sel = 1'b0;
        byte_in = 8'hFF;
        byte_valid = 1'b1;
        #1;
        check("ninth_ready", 64'(byte_ready), 64'd0);
        repeat (2) @(negedge clk);
        check("ninth_ready_hold", 64'(byte_ready), 64'd0);
        check("ninth_des_in", des_in, D2);
        byte_valid = 1'b0;
        send(1'b1, K1[7:0]);
        check("il_key_in", key_in, K1);
        wait_flag("il_flag_s");
        // bytes offered while busy must be ignored
        byte_sel = 1'b0;
        byte_in = 8'hAA;
        byte_valid = 1'b1;
        @(negedge clk);
        check("wait_ready", 64'(byte_ready), 64'd0);
        wait_valid("il_valid", lat);
        byte_valid = 1'b0;
        check("il_des_in", des_in, D2);
        for (int i = 0; i < 5; i++) begin
            des_out = 64'hDEAD_0000_0000_0000 + 64'(i);
            @(negedge clk);
            check("out_hold_res", res_out, RES);
            check("out_hold_rv", 64'(res_valid), 64'd1);
        end
        des_out = RES;
        handshake("il_hs");

        // reset pulse during WAIT discards the pending result
        load(D1, K1, 1'b1);
        wait_flag("wr_flag_s");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("wr_busy", 64'(busy), 64'd0);
        check("wr_ready", 64'(byte_ready), 64'd0);
        check("wr_bufs", 64'(des_in | key_in | res_out), 64'd0);
        check("wr_flags", {61'd0, flag_s, res_valid, key_err}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        rv0 = rv_cnt;
        repeat (30) @(negedge clk);
        check("wr_no_rv", 64'(rv_cnt - rv0), 64'd0);
        load(D2, K1, 1'b0);
        wait_flag("wr2_flag_s");
        wait_valid("wr2_valid", lat);
        check("wr2_latency", 64'(lat), 64'd18);
        check("wr2_res_out", res_out, RES);
        handshake("wr2_hs");

        // even-parity key byte 0x12
        for (int i = 0; i < 8; i++) send(1'b0, D1[63-8*i -: 8]);
        send(1'b1, 8'h12);
`ifdef DES_LOADER_PARITY_EN
        check("par_key_err", 64'(key_err), 64'd1);
        check("par_busy", 64'(busy), 64'd0);
        byte_sel = 1'b0;
        #1;
        check("par_dcnt_cleared", 64'(byte_ready), 64'd1);
        fs0 = fs_cnt;
        repeat (5) @(negedge clk);
        check("par_no_start", 64'(fs_cnt - fs0), 64'd0);
        check("par_sticky", 64'(key_err), 64'd1);
`else
        for (int i = 1; i < 8; i++) send(1'b1, K1[63-8*i -: 8]);
        check("par_key_in", key_in, 64'h123457799BBCDFF1);
        wait_flag("par_flag_s");
        wait_valid("par_valid", lat);
        check("par_res_out", res_out, RES);
        check("par_key_err", 64'(key_err), 64'd0);
        handshake("par_hs");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
